// File: rtl/regfile_bist_pkg.sv
// Shared types and pattern generator for the register-file BIST engine.
// Patterns are built at 64 bits and truncated by the user, so XLEN <= 64.
package regfile_bist_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FLUSH, DONE} state_t;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_NADDR = 2'd1;
  localparam logic [1:0] PAT_CHK   = 2'd2;
  localparam logic [1:0] PAT_ONES  = 2'd3;

  localparam int PAT_MAX_W = 64;

  function automatic logic [PAT_MAX_W-1:0] pat(input logic [1:0] sel,
                                               input logic [PAT_MAX_W-1:0] addr);
    case (sel)
      PAT_ADDR:  pat = addr;
      PAT_NADDR: pat = ~addr;
      PAT_CHK:   pat = addr[0] ? {32{2'b10}} : {32{2'b01}};
      default:   pat = '1;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bist_chk.sv
// Read-data checker: RD_LAT-deep expected/address delay line, comparator,
// saturating error counter and first-failure capture.
module regfile_bist_chk #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 0,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              clear,
  input  logic              vld,
  input  logic [XLEN-1:0]   e1,
  input  logic [XLEN-1:0]   e2,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [XLEN-1:0]   r1,
  input  logic [XLEN-1:0]   r2,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port
);

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] c,
                                               input logic [1:0] n);
    logic [ERR_W+1:0] s;
    s = {2'b00, c} + {{ERR_W{1'b0}}, n};
    if (s > {2'b00, {ERR_W{1'b1}}}) sat_add = '1;
    else sat_add = s[ERR_W-1:0];
  endfunction

  logic              vld_t;
  logic [XLEN-1:0]   e1_t, e2_t;
  logic [ADDR_W-1:0] a1_t, a2_t;

  generate
    if (RD_LAT == 0) begin : g_comb
      assign vld_t = vld;
      assign e1_t  = e1;
      assign e2_t  = e2;
      assign a1_t  = a1;
      assign a2_t  = a2;
    end else begin : g_dly
      logic [RD_LAT-1:0]             vld_p;
      logic [RD_LAT-1:0][XLEN-1:0]   e1_p, e2_p;
      logic [RD_LAT-1:0][ADDR_W-1:0] a1_p, a2_p;

      // stage boundary: expected values travel with the regfile read latency
      always_ff @(posedge clk) begin
        if (!resetb) vld_p <= '0;
        else begin
          vld_p[0] <= vld;
          for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        e1_p[0] <= e1;
        e2_p[0] <= e2;
        a1_p[0] <= a1;
        a2_p[0] <= a2;
        for (int k = 1; k < RD_LAT; k++) begin
          e1_p[k] <= e1_p[k-1];
          e2_p[k] <= e2_p[k-1];
          a1_p[k] <= a1_p[k-1];
          a2_p[k] <= a2_p[k-1];
        end
      end

      assign vld_t = vld_p[RD_LAT-1];
      assign e1_t  = e1_p[RD_LAT-1];
      assign e2_t  = e2_p[RD_LAT-1];
      assign a1_t  = a1_p[RD_LAT-1];
      assign a2_t  = a2_p[RD_LAT-1];
    end
  endgenerate

  logic mis1, mis2, captured;

  assign mis1 = vld_t && (r1 != e1_t);
  assign mis2 = vld_t && (r2 != e2_t);

  // stage boundary: compare results registered
  always_ff @(posedge clk) begin
    if (!resetb || clear) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
      captured  <= 1'b0;
    end else begin
      err_count <= sat_add(err_count, {1'b0, mis1} + {1'b0, mis2});
      if (!captured && (mis1 || mis2)) begin
        captured  <= 1'b1;
        fail_addr <= mis1 ? a1_t : a2_t;
        fail_port <= !mis1;
      end
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST controller: write sweep, dual-port read-back, pass/fail.
// Define REGFILE_BIST_R0_ZERO_EN to expect address 0 to read as hardwired zero.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 0,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_ad,
  output logic [XLEN-1:0]   rf_wd,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  input  logic [XLEN-1:0]   rf_r1,
  input  logic [XLEN-1:0]   rf_r2
);

  // One extra index bit so DEPTH == 2**ADDR_W terminates without wrapping.
  localparam int IDX_W = ADDR_W + 1;

  function automatic logic [XLEN-1:0] exp_val(input logic [1:0] sel,
                                              input logic [IDX_W-1:0] a);
    logic [XLEN-1:0] full;
    full = XLEN'(pat(sel, PAT_MAX_W'(a)));
`ifdef REGFILE_BIST_R0_ZERO_EN
    exp_val = (a == '0) ? '0 : full;
`else
    exp_val = full;
`endif
  endfunction

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n, ridx;
  logic [1:0]       pat_sel, pat_n;
  logic             accept, chk_vld;
  logic [XLEN-1:0]  e1, e2;

  assign accept = start && (state == IDLE || state == DONE);
  assign ridx   = IDX_W'(DEPTH - 1) - idx;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state   <= IDLE;
      idx     <= '0;
      pat_sel <= PAT_ADDR;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pat_sel <= pat_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pat_n   = pat_sel;
    busy    = 1'b0;
    done    = 1'b0;
    rf_we   = 1'b0;
    rf_ad   = '0;
    rf_wd   = '0;
    rf_a1   = '0;
    rf_a2   = '0;
    chk_vld = 1'b0;
    e1      = '0;
    e2      = '0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_n = WRITE;
          idx_n   = '0;
          pat_n   = pattern;
        end
      end
      WRITE: begin
        busy  = 1'b1;
        rf_we = 1'b1;
        rf_ad = idx[ADDR_W-1:0];
        rf_wd = XLEN'(pat(pat_sel, PAT_MAX_W'(idx)));
        if (idx == IDX_W'(DEPTH - 1)) begin
          state_n = READ;
          idx_n   = '0;
        end else idx_n = idx + 1'b1;
      end
      READ: begin
        busy    = 1'b1;
        chk_vld = 1'b1;
        rf_a1   = idx[ADDR_W-1:0];
        rf_a2   = ridx[ADDR_W-1:0];
        e1      = exp_val(pat_sel, idx);
        e2      = exp_val(pat_sel, ridx);
        if (idx == IDX_W'(DEPTH - 1)) begin
          state_n = (RD_LAT == 0) ? FLUSH : DRAIN;
          idx_n   = '0;
        end else idx_n = idx + 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
        if (idx == IDX_W'(RD_LAT - 1)) begin
          state_n = FLUSH;
          idx_n   = '0;
        end else idx_n = idx + 1'b1;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pass = done && (err_count == '0);

  regfile_bist_chk #(
    .XLEN  (XLEN),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .ERR_W (ERR_W)
  ) u_chk (
    .clk      (clk),
    .resetb   (resetb),
    .clear    (accept),
    .vld      (chk_vld),
    .e1       (e1),
    .e2       (e2),
    .a1       (rf_a1),
    .a2       (rf_a2),
    .r1       (rf_r1),
    .r2       (rf_r2),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .fail_port(fail_port)
  );

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench for regfile_bist: one instance with combinational-read regfile
// model (RD_LAT=0) and one with registered-read model (RD_LAT=1).
module tb_regfile_bist;

  logic clk = 1'b0;
  logic resetb, start;
  logic [1:0] pattern;

  always #5 clk = ~clk;

  logic        busy0, done0, pass0, fail_port0, rf_we0;
  logic [7:0]  err0;
  logic [4:0]  fail_addr0, rf_ad0, rf_a1_0, rf_a2_0;
  logic [31:0] rf_wd0, rf_r1_0, rf_r2_0;

  logic        busy1, done1, pass1, fail_port1, rf_we1;
  logic [7:0]  err1;
  logic [4:0]  fail_addr1, rf_ad1, rf_a1_1, rf_a2_1;
  logic [31:0] rf_wd1, rf_r1_1, rf_r2_1;

  int   vectors = 0, miscompares = 0;
  logic stuck = 1'b0, x0_zero = 1'b0, lat_fault = 1'b0, sel = 1'b0;

  regfile_bist #(.XLEN(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(0), .ERR_W(8)) dut0 (
    .clk(clk), .resetb(resetb), .start(start), .pattern(pattern),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_addr(fail_addr0), .fail_port(fail_port0),
    .rf_we(rf_we0), .rf_ad(rf_ad0), .rf_wd(rf_wd0),
    .rf_a1(rf_a1_0), .rf_a2(rf_a2_0), .rf_r1(rf_r1_0), .rf_r2(rf_r2_0));

  regfile_bist #(.XLEN(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .ERR_W(8)) dut1 (
    .clk(clk), .resetb(resetb), .start(start), .pattern(pattern),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_addr(fail_addr1), .fail_port(fail_port1),
    .rf_we(rf_we1), .rf_ad(rf_ad1), .rf_wd(rf_wd1),
    .rf_a1(rf_a1_1), .rf_a2(rf_a2_1), .rf_r1(rf_r1_1), .rf_r2(rf_r2_1));

  // Regfile model 0: combinational read, optional stuck bit and hardwired x0.
  logic [31:0] mem0 [32];
  always @(posedge clk)
    if (rf_we0 && !(x0_zero && rf_ad0 == 5'd0))
      mem0[rf_ad0] <= (stuck && rf_ad0 == 5'd7) ? (rf_wd0 & ~32'h8) : rf_wd0;
  assign rf_r1_0 = (x0_zero && rf_a1_0 == 5'd0) ? 32'h0 : mem0[rf_a1_0];
  assign rf_r2_0 = (x0_zero && rf_a2_0 == 5'd0) ? 32'h0 : mem0[rf_a2_0];

  // Regfile model 1: registered read; lat_fault bypasses the register.
  logic [31:0] mem1 [32];
  logic [31:0] q1, q2;
  always @(posedge clk) begin
    if (rf_we1) mem1[rf_ad1] <= rf_wd1;
    q1 <= mem1[rf_a1_1];
    q2 <= mem1[rf_a2_1];
  end
  assign rf_r1_1 = lat_fault ? mem1[rf_a1_1] : q1;
  assign rf_r2_1 = lat_fault ? mem1[rf_a2_1] : q2;

  logic       busy_m, done_m, pass_m, we_m, fail_port_m;
  logic [7:0] err_m;
  logic [4:0] fail_addr_m;
  assign busy_m      = sel ? busy1 : busy0;
  assign done_m      = sel ? done1 : done0;
  assign pass_m      = sel ? pass1 : pass0;
  assign we_m        = sel ? rf_we1 : rf_we0;
  assign err_m       = sel ? err1 : err0;
  assign fail_addr_m = sel ? fail_addr1 : fail_addr0;
  assign fail_port_m = sel ? fail_port1 : fail_port0;

  // Leaves the bench #1 after the edge that sampled start.
  task automatic pulse_start(input logic [1:0] p);
    repeat (3) @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n = clocks from the start edge to the edge where done is first seen.
  task automatic wait_done(input int repulse_at, output int n, output int we_n);
    n = 0;
    we_n = 0;
    while (!done_m && n < 300) begin
      if (we_m) we_n++;
      @(posedge clk);
      #1 n++;
      start = (n == repulse_at);
    end
    start = 1'b0;
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout got no done after %0d clocks", n);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; pattern = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done0); end
    vectors++; if (pass0 !== 1'b0) begin miscompares++; $display("FAIL rst_pass got %b want 0", pass0); end
    vectors++; if (err0 !== 8'd0) begin miscompares++; $display("FAIL rst_err got %0d want 0", err0); end
    vectors++; if (fail_addr0 !== 5'd0) begin miscompares++; $display("FAIL rst_fail_addr got %0d want 0", fail_addr0); end
    vectors++; if (fail_port0 !== 1'b0) begin miscompares++; $display("FAIL rst_fail_port got %b want 0", fail_port0); end
    vectors++; if (rf_we0 !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", rf_we0); end
    vectors++; if ({rf_ad0, rf_a1_0, rf_a2_0} !== 15'd0) begin miscompares++; $display("FAIL rst_addrs got %h want 0", {rf_ad0, rf_a1_0, rf_a2_0}); end
    vectors++; if (rf_wd0 !== 32'd0) begin miscompares++; $display("FAIL rst_wd got %h want 0", rf_wd0); end
    resetb = 1'b1;
  endtask

  task automatic test_basic();
    int n, we_n;
    sel = 1'b0;
    pulse_start(2'd0);
    wait_done(-1, n, we_n);
    vectors++; if (n !== 65) begin miscompares++; $display("FAIL basic_latency got %0d want 65", n); end
    vectors++; if (we_n !== 32) begin miscompares++; $display("FAIL basic_we_cycles got %0d want 32", we_n); end
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL basic_pass got %b want 1", pass_m); end
    vectors++; if (err_m !== 8'd0) begin miscompares++; $display("FAIL basic_err got %0d want 0", err_m); end
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b want 0", busy_m); end
  endtask

  task automatic test_stuck_bit();
    int n, we_n;
    sel = 1'b0; stuck = 1'b1;
    pulse_start(2'd3);
    wait_done(-1, n, we_n);
    vectors++; if (err_m !== 8'd2) begin miscompares++; $display("FAIL stuck_err got %0d want 2", err_m); end
    vectors++; if (fail_addr_m !== 5'd7) begin miscompares++; $display("FAIL stuck_fail_addr got %0d want 7", fail_addr_m); end
    vectors++; if (fail_port_m !== 1'b0) begin miscompares++; $display("FAIL stuck_fail_port got %b want 0", fail_port_m); end
    vectors++; if (pass_m !== 1'b0) begin miscompares++; $display("FAIL stuck_pass got %b want 0", pass_m); end
    stuck = 1'b0;
  endtask

  task automatic test_restart_from_done();
    int n, we_n;
    sel = 1'b0;
    pulse_start(2'd1);
    vectors++; if (done_m !== 1'b0) begin miscompares++; $display("FAIL restart_done_clr got %b want 0", done_m); end
    vectors++; if (err_m !== 8'd0) begin miscompares++; $display("FAIL restart_err_clr got %0d want 0", err_m); end
    vectors++; if (fail_addr_m !== 5'd0) begin miscompares++; $display("FAIL restart_addr_clr got %0d want 0", fail_addr_m); end
    vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b want 1", busy_m); end
    wait_done(-1, n, we_n);
    vectors++; if (n !== 65) begin miscompares++; $display("FAIL restart_latency got %0d want 65", n); end
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL restart_pass got %b want 1", pass_m); end
  endtask

  task automatic test_repulse();
    int n, we_n;
    sel = 1'b0;
    pulse_start(2'd0);
    wait_done(10, n, we_n);
    vectors++; if (n !== 65) begin miscompares++; $display("FAIL repulse_latency got %0d want 65", n); end
    vectors++; if (we_n !== 32) begin miscompares++; $display("FAIL repulse_we_cycles got %0d want 32", we_n); end
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL repulse_pass got %b want 1", pass_m); end
  endtask

  task automatic test_x0_zero();
    int n, we_n;
    sel = 1'b0; x0_zero = 1'b1;
    pulse_start(2'd3);
    wait_done(-1, n, we_n);
`ifdef REGFILE_BIST_R0_ZERO_EN
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL x0_pass got %b want 1", pass_m); end
    vectors++; if (err_m !== 8'd0) begin miscompares++; $display("FAIL x0_err got %0d want 0", err_m); end
`else
    vectors++; if (err_m !== 8'd2) begin miscompares++; $display("FAIL x0_err got %0d want 2", err_m); end
    vectors++; if (fail_addr_m !== 5'd0) begin miscompares++; $display("FAIL x0_fail_addr got %0d want 0", fail_addr_m); end
    vectors++; if (fail_port_m !== 1'b0) begin miscompares++; $display("FAIL x0_fail_port got %b want 0", fail_port_m); end
    vectors++; if (pass_m !== 1'b0) begin miscompares++; $display("FAIL x0_pass got %b want 0", pass_m); end
`endif
    x0_zero = 1'b0;
  endtask

  task automatic test_rd_lat1();
    int n, we_n;
    sel = 1'b1;
    pulse_start(2'd2);
    wait_done(-1, n, we_n);
    vectors++; if (n !== 66) begin miscompares++; $display("FAIL lat1_latency got %0d want 66", n); end
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL lat1_pass got %b want 1", pass_m); end
    lat_fault = 1'b1;
    pulse_start(2'd2);
    wait_done(-1, n, we_n);
    vectors++; if (err_m === 8'd0) begin miscompares++; $display("FAIL lat1_fault_err got %0d want nonzero", err_m); end
    vectors++; if (pass_m !== 1'b0) begin miscompares++; $display("FAIL lat1_fault_pass got %b want 0", pass_m); end
    lat_fault = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_abort();
    int n, we_n;
    sel = 1'b0; stuck = 1'b1;
    pulse_start(2'd3);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    vectors++; if (err_m !== 8'd1) begin miscompares++; $display("FAIL abort_pre_err got %0d want 1", err_m); end
    resetb = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy_m); end
    vectors++; if (we_m !== 1'b0) begin miscompares++; $display("FAIL abort_we got %b want 0", we_m); end
    vectors++; if (err_m !== 8'd0) begin miscompares++; $display("FAIL abort_err got %0d want 0", err_m); end
    vectors++; if (done_m !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", done_m); end
    resetb = 1'b1; stuck = 1'b0;
    pulse_start(2'd0);
    wait_done(-1, n, we_n);
    vectors++; if (n !== 65) begin miscompares++; $display("FAIL abort_rerun_latency got %0d want 65", n); end
    vectors++; if (pass_m !== 1'b1) begin miscompares++; $display("FAIL abort_rerun_pass got %b want 1", pass_m); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_bit();
    test_restart_from_done();
    test_repulse();
    test_x0_zero();
    test_rd_lat1();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
Name: regfile_bist

Overview:
Parametrised built-in self-test controller for the register file.
- Sweeps every address with a selectable data pattern, then reads back through both read ports with different address orders.
- Counts mismatches and records the first failing address and port.
- Sits beside the regfile, muxed onto its ports in test mode. Replaces ad-hoc free-running counter benches with a start/done, pass/fail engine.

Parameters:
XLEN, 32, data width of regfile words
ADDR_W, 5, address width
DEPTH, 32, registers tested (addresses 0..DEPTH-1), DEPTH <= 2**ADDR_W, DEPTH >= 2
RD_LAT, 0, regfile read latency in cycles (0 = combinational read, 1 = registered read)
ERR_W, 8, error counter width (saturating)

Ports:
clk  in  1  clock
resetb  in  1  reset, synchronous, active-low
start  in  1  pulse; begins a run when sampled in IDLE or DONE
pattern  in  2  pattern select, latched at start
busy  out  1  run in progress
done  out  1  run complete; held until next accepted start
pass  out  1  valid with done; 1 iff err_count == 0
err_count  out  ERR_W  mismatch count, saturates at all-ones
fail_addr  out  ADDR_W  address of first mismatch (0 if none)
fail_port  out  1  port of first mismatch: 0 = r1, 1 = r2
rf_we  out  1  regfile write enable
rf_ad  out  ADDR_W  regfile write address
rf_wd  out  XLEN  regfile write data
rf_a1  out  ADDR_W  read address, port 1
rf_a2  out  ADDR_W  read address, port 2
rf_r1  in  XLEN  read data, port 1
rf_r2  in  XLEN  read data, port 2

Behaviour:
- Reset: state IDLE; busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_port=0, rf_we=0, all rf address and data outputs 0.
- Reset is honoured in any state. Mid-run reset aborts immediately: rf_we=0 on the next cycle, no partial result is kept.
- States: IDLE -> WRITE -> READ -> DRAIN (RD_LAT cycles; skipped when RD_LAT=0) -> FLUSH (1 cycle) -> DONE. DONE -> WRITE on start.
- Accepted start: latches pattern, clears err_count, fail_addr, fail_port and done. start while busy is ignored.
- WRITE: DEPTH cycles, idx = 0..DEPTH-1.
  - rf_we=1, rf_ad=idx, rf_wd=pat(idx).
  - rf_we=0 in every other state.
- READ: DEPTH cycles, idx = 0..DEPTH-1.
  - rf_a1=idx, expected e1=pat(idx).
  - rf_a2=DEPTH-1-idx, expected e2=pat(DEPTH-1-idx).
- Compare:
  - Expected values and addresses are delayed by RD_LAT cycles to align with rf_r1/rf_r2.
  - Each port mismatch adds 1 to err_count; up to 2 per cycle.
  - Saturates at 2**ERR_W-1, no wrap.
- First mismatch: fail_addr/fail_port are captured once per run. If both ports miss in the same first cycle, port 1 wins.
- FLUSH: lets the final compare register. done rises exactly 2*DEPTH+RD_LAT+1 clocks after the edge that sampled start; busy falls on the same edge.
- Patterns, pat(a):
  - 0: a zero-extended to XLEN
  - 1: bitwise NOT of pattern 0
  - 2: checkerboard, 0x55..55 for even a, 0xAA..AA for odd a
  - 3: all-ones
- Index counter width is ADDR_W+1 so DEPTH = 2**ADDR_W terminates without wrap.

Optional Feature:
REGFILE_BIST_R0_ZERO_EN
- Defined: address 0 is treated as hardwired zero. The expected read value at address 0 is 0 on both ports, for all patterns; the write is still issued.
- Undefined: address 0 is checked like every other address.

Decomposition:
- Package regfile_bist_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, FLUSH, DONE)
  - pattern encoding constants PAT_ADDR, PAT_NADDR, PAT_CHK, PAT_ONES
  - pattern function pat(sel, addr)
- One natural sub-module: regfile_bist_chk, the RD_LAT-deep expected/address delay line plus comparator, error counter and first-fail capture.

Test Plan:
- Ideal regfile model, DEPTH=32, RD_LAT=0, pattern 0, start pulse -> done=1 and pass=1 exactly 65 clocks after start edge; err_count=0; rf_we high for exactly 32 cycles.
- Regfile model with bit 3 of register 7 stuck at 0, pattern 3 -> err_count=2 (port1 idx 7, port2 idx 24), fail_addr=7, fail_port=0, pass=0.
- Hardwired-zero x0 model, pattern 3:
  - macro defined -> pass=1
  - undefined -> err_count=2, fail_addr=0, fail_port=0
- RD_LAT=1 with registered-read model, pattern 2 -> pass=1, done at clock 66. Inject read data delayed by 0 instead of 1 -> err_count nonzero.
- Reset asserted at clock 40 of a run -> next cycle busy=0, rf_we=0, err_count=0. Subsequent start completes a normal passing run.
- start re-pulsed at clock 10 of a run -> ignored, done still at 65. start in DONE with pattern 1 -> new run; done/err cleared on accept.
